// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the SDF FFT stage.
`default_nettype none

package fft_pkg;

   localparam int  SAMPLE_DW = 13;
   localparam real PI        = 3.14159265358979323846;

   // Stored/output complex sample: one guard bit above the input width.
   typedef struct packed {
      logic signed [SAMPLE_DW:0] re;
      logic signed [SAMPLE_DW:0] im;
   } cplx_t;

   function automatic int clog2_c(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic real taylor_cos(input real x);
      real term;
      real sum;
      term = 1.0;
      sum  = 1.0;
      for (int n = 1; n < 24; n++) begin
         term = -term * x * x / ((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // W^k = cos(2*pi*k/n) - j*sin(2*pi*k/n), scaled so 1.0 = 2^(tw_w-2),
   // rounded to nearest with ties away from zero.
   function automatic int tw_quant(input int k, input int n, input int tw_w, input bit imag_part);
      real ang;
      real v;
      ang = 2.0 * PI * $itor(k) / $itor(n);
      v   = imag_part ? -taylor_cos(PI / 2.0 - ang) : taylor_cos(ang);
      v   = v * $itor(1 << (tw_w - 2));
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle table W^k, k = 0..N/2-1, built at elaboration.
`default_nettype none

module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int N    = 8,
   parameter int TW_W = 10,
   localparam int LOG2N = clog2_c(N),
   localparam int KW    = (LOG2N > 1) ? LOG2N - 1 : 1
) (
   input  logic        [KW-1:0]   k,
   output logic signed [TW_W-1:0] w_re,
   output logic signed [TW_W-1:0] w_im
);

   logic signed [TW_W-1:0] tab_re [2**KW];
   logic signed [TW_W-1:0] tab_im [2**KW];

   for (genvar i = 0; i < 2**KW; i++) begin : g_tab
      localparam logic signed [TW_W-1:0] C_RE = TW_W'(tw_quant(i, N, TW_W, 1'b0));
      localparam logic signed [TW_W-1:0] C_IM = TW_W'(tw_quant(i, N, TW_W, 1'b1));
      assign tab_re[i] = C_RE;
      assign tab_im[i] = C_IM;
   end

   assign w_re = tab_re[k];
   assign w_im = tab_im[k];

endmodule

`default_nettype wire

// File: rtl/fft_sdf_stage.sv
// Single-path delay-feedback radix-2 FFT stage (butterfly + twiddle, N/2 delay).
// Optional FFT_SDF_SCALE_EN: halve butterfly sum/difference and twiddle product.
`default_nettype none

module fft_sdf_stage
   import fft_pkg::*;
#(
   parameter int DW   = SAMPLE_DW,
   parameter int N    = 8,
   parameter int TW_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic                 out_valid,
   output logic signed [DW:0]   out_real,
   output logic signed [DW:0]   out_imag
);

   localparam int LOG2N = clog2_c(N);
   localparam int CW    = LOG2N;
   localparam int KW    = (LOG2N > 1) ? LOG2N - 1 : 1;
   localparam int HALF  = N / 2;
   localparam int PW    = DW + TW_W + 2;

   localparam logic signed [PW-1:0] RND  = PW'(1 << (TW_W - 3));
   localparam logic signed [PW-1:0] MAXV = PW'((1 << DW) - 1);
   localparam logic signed [PW-1:0] MINV = PW'(-(1 << DW));

   if (DW != SAMPLE_DW) begin : g_dw_check
      $error("fft_sdf_stage: DW must match fft_pkg::SAMPLE_DW");
   end

   logic [CW-1:0]          cnt;
   logic                   primed;
   cplx_t                  dly [HALF];
   cplx_t                  d, sum, diff, prod, res, din;
   logic signed [DW:0]     x_re, x_im;
   logic signed [TW_W-1:0] w_re, w_im;
   logic signed [PW-1:0]   p_re, p_im;

   function automatic logic signed [DW:0] sat(input logic signed [PW-1:0] v);
      if (v > MAXV) return MAXV[DW:0];
      if (v < MINV) return MINV[DW:0];
      return v[DW:0];
   endfunction

   function automatic logic signed [DW:0] scl(input logic signed [DW:0] v);
`ifdef FFT_SDF_SCALE_EN
      return v >>> 1;
`else
      return v;
`endif
   endfunction

   fft_twiddle_rom #(.N(N), .TW_W(TW_W)) u_rom (
      .k    (cnt[KW-1:0]),
      .w_re (w_re),
      .w_im (w_im)
   );

   assign d    = dly[HALF-1];
   assign x_re = {in_real[DW-1], in_real};
   assign x_im = {in_imag[DW-1], in_imag};

   always_comb begin
      sum.re  = scl(d.re + x_re);
      sum.im  = scl(d.im + x_im);
      diff.re = scl(d.re - x_re);
      diff.im = scl(d.im - x_im);
      // Full-precision complex multiply, round half up, then narrow.
      p_re    = PW'(d.re) * PW'(w_re) - PW'(d.im) * PW'(w_im) + RND;
      p_im    = PW'(d.re) * PW'(w_im) + PW'(d.im) * PW'(w_re) + RND;
      prod.re = scl(sat(p_re >>> (TW_W - 2)));
      prod.im = scl(sat(p_im >>> (TW_W - 2)));
      if (cnt[CW-1]) begin
         res = sum;
         din = diff;
      end else begin
         res    = prod;
         din.re = x_re;
         din.im = x_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         primed    <= 1'b0;
         out_valid <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
         for (int i = 0; i < HALF; i++) dly[i] <= '0;
      end else begin
         out_valid <= in_valid & primed;
         if (in_valid) begin
            cnt      <= cnt + CW'(1);
            out_real <= res.re;
            out_imag <= res.im;
            if (cnt == CW'(HALF - 1)) primed <= 1'b1;
            dly[0] <= din;
            for (int i = 1; i < HALF; i++) dly[i] <= dly[i-1];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_stage.sv
// Randomised bench for fft_sdf_stage against a frame-level butterfly model.
`timescale 1ns/1ps
`default_nettype none

module tb_fft_sdf_stage;

   localparam int DW   = 13;
   localparam int N    = 8;
   localparam int TW_W = 10;
   localparam int HALF = N / 2;
   localparam int OMAX = (1 << DW) - 1;
   localparam int OMIN = -(1 << DW);

   logic                 clk      = 1'b0;
   logic                 rst      = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_real  = '0;
   logic signed [DW-1:0] in_imag  = '0;
   logic                 out_valid;
   logic signed [DW:0]   out_real;
   logic signed [DW:0]   out_imag;

   int n_checks = 0;
   int n_fail   = 0;
   int xr[$];
   int xi[$];
   int last_re  = 0;
   int last_im  = 0;

   fft_sdf_stage #(.DW(DW), .N(N), .TW_W(TW_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_real  (out_real),
      .out_imag  (out_imag)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   function automatic int sat(input longint v);
      if (v > OMAX) return OMAX;
      if (v < OMIN) return OMIN;
      return int'(v);
   endfunction

   function automatic int scl(input int v);
`ifdef FFT_SDF_SCALE_EN
      return v >>> 1;
`else
      return v;
`endif
   endfunction

   // Output for the s-th accepted sample since reset, from frame arithmetic:
   // second half of frame f gives x[n-N/2] + x[n]; first half of frame f+1
   // gives (x[m] - x[m+N/2]) * W^m of frame f.
   function automatic void model(input int s, output bit v, output int er, output int ei);
      int     idx;
      int     dr, di, wr, wi;
      real    a, sc;
      longint pr, pim;
      idx = s % N;
      v   = (s >= HALF);
      if (idx >= HALF) begin
         er = scl(xr[s-HALF] + xr[s]);
         ei = scl(xi[s-HALF] + xi[s]);
      end else if (s < N) begin
         er = 0;
         ei = 0;
      end else begin
         dr  = scl(xr[s-N] - xr[s-HALF]);
         di  = scl(xi[s-N] - xi[s-HALF]);
         a   = 2.0 * 3.14159265358979323846 * $itor(idx) / $itor(N);
         sc  = $itor(1 << (TW_W - 2));
         wr  = rnd($cos(a) * sc);
         wi  = rnd(-$sin(a) * sc);
         pr  = longint'(dr) * wr - longint'(di) * wi + (1 << (TW_W - 3));
         pim = longint'(dr) * wi + longint'(di) * wr + (1 << (TW_W - 3));
         er  = scl(sat(pr >>> (TW_W - 2)));
         ei  = scl(sat(pim >>> (TW_W - 2)));
      end
   endfunction

   task automatic send(input int re, input int im);
      bit v;
      int er, ei, s;
      in_valid = 1'b1;
      in_real  = DW'(re);
      in_imag  = DW'(im);
      xr.push_back(re);
      xi.push_back(im);
      s = xr.size() - 1;
      model(s, v, er, ei);
      @(posedge clk);
      #1;
      check_eq($sformatf("valid[s=%0d]", s), int'(out_valid), int'(v));
      check_eq($sformatf("re[s=%0d]", s), int'(out_real), er);
      check_eq($sformatf("im[s=%0d]", s), int'(out_imag), ei);
      last_re = er;
      last_im = ei;
   endtask

   task automatic stall(input int cycles);
      in_valid = 1'b0;
      in_real  = DW'($urandom);
      in_imag  = DW'($urandom);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         check_eq("stall_valid", int'(out_valid), 0);
         check_eq("stall_re_hold", int'(out_real), last_re);
         check_eq("stall_im_hold", int'(out_imag), last_im);
      end
   endtask

   // Samples presented while rst is high must be dropped.
   task automatic do_reset(input int cycles);
      rst      = 1'b1;
      in_valid = 1'b1;
      repeat (cycles) begin
         in_real = DW'($urandom);
         in_imag = DW'($urandom);
         @(posedge clk);
         #1;
         check_eq("rst_valid", int'(out_valid), 0);
         check_eq("rst_re", int'(out_real), 0);
         check_eq("rst_im", int'(out_imag), 0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      xr.delete();
      xi.delete();
      last_re = 0;
      last_im = 0;
   endtask

   function automatic int rx();
      return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
   endfunction

   initial begin
      do_reset(2);

      // Impulse over two frames.
      send(100, 0);
      for (int i = 1; i < 2 * N; i++) send(0, 0);

      // Same impulse stream with a 3-cycle stall at frame index 5.
      do_reset(2);
      send(100, 0);
      for (int i = 1; i < 2 * N; i++) begin
         if (i == 5) stall(3);
         send(0, 0);
      end

      // DC, then both-component negative extremes.
      do_reset(2);
      for (int i = 0; i < 2 * N; i++) send(50, 0);
      for (int i = 0; i < 2 * N; i++) send(-(1 << (DW - 1)), -(1 << (DW - 1)));

      // Single tone sample at index 1; check the W^1 product explicitly.
      do_reset(2);
      for (int i = 0; i < N; i++) send((i == 1) ? 1000 : 0, 0);
      for (int i = 0; i < N; i++) begin
         send(0, 0);
         if (i == 1) begin
`ifdef FFT_SDF_SCALE_EN
            check_eq("tw1_re", int'(out_real), 177);
            check_eq("tw1_im", int'(out_imag), -177);
`else
            check_eq("tw1_re", int'(out_real), 707);
            check_eq("tw1_im", int'(out_imag), -707);
`endif
         end
      end

      // Random traffic with random stalls and a mid-frame reset.
      do_reset(2);
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 4) == 0) stall(int'($urandom_range(1, 3)));
         if (t == 203) do_reset(int'($urandom_range(1, 3)));
         send(rx(), rx());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/fft_sdf_stage.md
FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

Interface
REQ-001 Parameter DW, 13: input sample width per component, signed two's complement.
REQ-002 Parameter N, 8: stage span in points, power of two, 2..1024; delay depth is N/2.
REQ-003 Parameter TW_W, 10: twiddle width, signed; 1.0 = 2^(TW_W-2).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input sample accepted on a clk edge when high.
REQ-007 in_real, in_imag  in  DW each  signed input sample.
REQ-008 out_valid  out  1  output sample valid.
REQ-009 out_real, out_imag  out  DW+1 each  signed output sample, registered.

Function
REQ-010 Frame counter cnt, log2(N) bits, SHALL increment once per accepted sample and wrap N-1 -> 0; cnt holds when in_valid=0.
REQ-011 Delay line SHALL hold N/2 complex entries of DW+1 bits; it SHALL shift only on accepted samples; d = oldest entry.
REQ-012 Phase A (cnt < N/2): output = d * W^k with k = cnt; delay input = x sign-extended to DW+1.
REQ-013 Phase B (cnt >= N/2): output = d + x; delay input = d - x; both computed at DW+1 bits, no overflow possible.
REQ-014 W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), quantised round-to-nearest to TW_W bits.
REQ-015 Complex product SHALL use full-precision partial products, add 2^(TW_W-3), arithmetic-shift right by TW_W-2, then saturate to DW+1 bits.
REQ-016 k = 0 SHALL pass d exactly (no rounding error).
REQ-017 Output registers SHALL update one cycle after each accepted sample; latency input-to-output = 1 clk.
REQ-018 out_valid SHALL be high exactly one cycle after an accepted sample once primed; primed sets after the first N/2 accepted samples following reset and stays set.
REQ-019 When in_valid=0, out_valid SHALL drop next cycle and out_real/out_imag SHALL hold their last value.
REQ-020 Stalls of any length SHALL not alter the output sequence relative to an unstalled stream.

Reset
REQ-021 On rst: cnt = 0, primed = 0, all delay entries = 0, out_valid = 0, out_real = out_imag = 0.
REQ-022 rst SHALL take precedence over in_valid in the same cycle; the sample presented is discarded.
REQ-023 Reset mid-frame SHALL abandon the frame; first accepted sample after rst deasserts is frame index 0.

Configuration
REQ-024 Macro FFT_SDF_SCALE_EN: when defined, the Phase B sum and difference and the Phase A product SHALL be arithmetic-shifted right by 1 (truncation) before registering/storing; when undefined, no scaling; port widths identical in both builds.

Structure
REQ-025 Shared package fft_pkg SHALL hold the complex sample typedef, the twiddle quantisation function and the log2 constant helper.
REQ-026 One sub-module fft_twiddle_rom SHALL provide W^k (real, imag) for k = 0..N/2-1, combinational, parameterised by N and TW_W.

Verification (N=8, DW=13, TW_W=10)
REQ-027 Reset: rst high 2 cycles during traffic -> out_valid=0, outputs 0; first post-reset sample handled as cnt=0.
REQ-028 Impulse: two frames, x0=100 then zeros -> frame-1 Phase B outputs (100,0),0,0,0; frame-2 Phase A outputs (100,0),0,0,0.
REQ-029 DC: all samples (50,0) -> Phase B outputs (100,0); following Phase A outputs 0.
REQ-030 Twiddle: frame with x1=(1000,0), rest 0 -> next-frame Phase A output at cnt=1 = (707,-707).
REQ-031 Stall: in_valid low 3 cycles at cnt=5 -> out_valid low those cycles; sequence identical to REQ-028 stream.
REQ-032 FFT_SDF_SCALE_EN defined, DC (50,0) -> Phase B outputs (50,0); extremes -4096+-4096 -> -4096, no wrap.
